dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the word-address width of every address port.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of every data port.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req0, req1  input  1 each  access request from port 0 (CPU) and port 1 (DMA/debug).
REQ-007 we0, we1  input  1 each  1 = write, 0 = read; held stable with req.
REQ-008 addr0, addr1  input  ADDR_W each  word address; held stable with req.
REQ-009 wdata0, wdata1  input  DATA_W each  write data; held stable with req.
REQ-010 gnt0, gnt1  output  1 each  one-cycle pulse, command accepted.
REQ-011 rvalid0, rvalid1  output  1 each  one-cycle pulse, read data valid.
REQ-012 rdata0, rdata1  output  DATA_W each  registered read data.
REQ-013 mem_read_address, mem_write_address  output  ADDR_W each  memory read/write addresses.
REQ-014 mem_write_data  output  DATA_W  memory write data.
REQ-015 mem_write_enable  output  1  memory write strobe.
REQ-016 mem_read_data  input  DATA_W  memory combinational read data for mem_read_address.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, RESP; reset state IDLE.
REQ-018 IDLE: with any req high at a clock edge, arbiter SHALL latch winner's we/addr/wdata and port id, go to ACCESS, and assert that port's gnt for the following cycle only.
REQ-019 Arbitration: single requester wins; both high -> port not granted last wins (round-robin); last-grant register resets to port 1, so port 0 wins the first contention.
REQ-020 ACCESS (exactly one cycle): mem_read_address and mem_write_address SHALL both equal latched addr; mem_write_data = latched wdata; mem_write_enable = latched we.
REQ-021 ACCESS read: mem_read_data SHALL be captured at the edge ending ACCESS into winner's rdata; winner's rvalid high during RESP only.
REQ-022 ACCESS write: no rvalid; rdata unchanged.
REQ-023 RESP lasts one cycle then returns to IDLE; req not sampled in ACCESS or RESP.
REQ-024 Latency: req seen at edge E -> gnt during cycle E+1, memory access in same cycle, rvalid during cycle E+2; max throughput one access per 3 cycles.
REQ-025 Requester SHALL change req/command at the edge where its gnt is high; an unchanged high req is a new request.
REQ-026 Outside ACCESS: mem_write_enable = 0, memory addresses and write data = 0.
REQ-027 gnt0/gnt1 never high together; rvalid0/rvalid1 never high together.
REQ-028 rdataN SHALL hold its last value until the next read completion for port N.
REQ-029 Address SHALL be passed unmodified; no wrap or range check.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, last-grant = port 1, all gnt/rvalid/mem_write_enable = 0, rdata and memory address/data outputs = 0.
REQ-031 Reset during ACCESS SHALL abort the write (enable drops asynchronously) and suppress rvalid; no transaction resumes after release.
REQ-032 First req sampling SHALL occur at the first rising edge with rst_n high.

Verification
REQ-033 Port 0 write addr 0x10 data 0xDEADBEEF -> gnt0 one cycle, mem_write_enable=1 with mem_write_address=0x10 that cycle, no rvalid0.
REQ-034 Port 1 read addr 0x10 after REQ-033 -> gnt1, then rvalid1 with rdata1=0xDEADBEEF two cycles after req sampled.
REQ-035 req0 and req1 high continuously from reset, reads of 0x01/0x02 -> grants alternate 0,1,0,1 every 3 cycles; port 0 first.
REQ-036 Single requester port 1 held high for 4 accesses -> four gnt1 pulses 3 cycles apart, gnt0 never high.
REQ-037 rst_n low during ACCESS of write 0x20 -> mem_write_enable falls same time, no rvalid, FSM IDLE after release.
REQ-038 Idle (no req) 10 cycles -> mem_write_enable, gnt, rvalid all 0; memory address/data outputs 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-port data memory
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              take;
  logic              win;
  logic              last_gnt;
  logic              lat_port;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  // Winner: lone requester, otherwise the port that was not granted last.
  always_comb begin
    state_nxt         = state;
    take              = 1'b0;
    win               = req1;
    gnt0              = 1'b0;
    gnt1              = 1'b0;
    rvalid0           = 1'b0;
    rvalid1           = 1'b0;
    mem_read_address  = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_write_enable  = 1'b0;
    if (req0 && req1) win = ~last_gnt;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = ACCESS;
          take      = 1'b1;
        end
      end
      ACCESS: begin
        state_nxt         = RESP;
        gnt0              = ~lat_port;
        gnt1              = lat_port;
        mem_read_address  = lat_addr;
        mem_write_address = lat_addr;
        mem_write_data    = lat_wdata;
        mem_write_enable  = lat_we;
      end
      RESP: begin
        state_nxt = IDLE;
        rvalid0   = ~lat_we & ~lat_port;
        rvalid1   = ~lat_we & lat_port;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        lat_port  <= win;
        last_gnt  <= win;
        lat_we    <= win ? we1 : we0;
        lat_addr  <= win ? addr1 : addr0;
        lat_wdata <= win ? wdata1 : wdata0;
      end
      // Read data is captured on the edge that ends the access cycle.
      if (state == ACCESS && !lat_we) begin
        if (lat_port) rdata1 <= mem_read_data;
        else          rdata0 <= mem_read_data;
      end
    end
  end

endmodule
